// File: rtl/serial_rx_param.sv
// serial_rx_param
//   Oversampling asynchronous serial receiver. Each frame is a start bit,
//   DATA_BITS data bits (LSB first), an optional parity bit and STOP_BITS
//   stop bits. Every bit is CLKS_PER_BIT clocks long and is sampled at its
//   midpoint. A completed word is held on the outputs until acknowledged.
//   A word that completes while the previous one is still held replaces it
//   and raises the sticky overrun flag.
//
// Parameters
//   DATA_BITS    data bits per frame (5..9)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    1 or 2
//   CLKS_PER_BIT clocks per bit (4..65535)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   serial_in    serial line, idle high, asynchronous to clk
//   data_ack     consumer accepts the held word (ignored while ready = 0)
//   ready        held word valid
//   data_out     held word, bit 0 = first data bit on the line
//   parity_ok_n  1 = parity error in the held word
//   frame_err    1 = a stop bit of the held word was sampled low
//   overrun      sticky, a held word was replaced before being acknowledged
module serial_rx_param #(
    parameter int DATA_BITS    = 7,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 data_ack,
    output logic                 ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_ok_n,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    // The start bit is sampled half a bit after the falling edge is seen;
    // the counter is cleared on that edge, so the compare value is H-1.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_PARITY = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state_q;
    logic                 sync_q;
    logic                 line_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 stop_err_q;
    logic                 done_q;      // one-cycle strobe: frame finished last cycle

    logic                 ready_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 parity_q;
    logic                 frame_q;
    logic                 overrun_q;

    logic                 half_hit_d;
    logic                 bit_hit_d;
    logic                 ack_take_d;
    logic                 ready_d;
    logic                 overrun_d;

    assign half_hit_d = (cnt_q == HALF_LAST);
    assign bit_hit_d  = (cnt_q == BIT_LAST);

    // Handshake: a completion always (re)asserts ready. An acknowledge of a
    // held word clears overrun, but a completion that lands on a held,
    // unacknowledged word sets it.
    always_comb begin
        ack_take_d = ready_q & data_ack;
        ready_d    = done_q | (ready_q & ~data_ack);
        overrun_d  = (done_q & ready_q & ~data_ack) | (overrun_q & ~ack_take_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync_q     <= 1'b1;
            line_q     <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            frame_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_q    <= serial_in;
            line_q    <= sync_q;
            done_q    <= 1'b0;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;

            // The shift register and status flags stay untouched for at
            // least half a bit after the last stop sample, so they are
            // still those of the finished frame here.
            if (done_q) begin
                data_q   <= shift_q;
                parity_q <= par_err_q;
                frame_q  <= stop_err_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (!line_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end

                S_START: begin
                    if (half_hit_d) begin
                        cnt_q <= '0;
                        if (line_q) begin
                            // Low pulse shorter than half a bit: ignore it.
                            state_q <= S_IDLE;
                        end else begin
                            state_q    <= S_DATA;
                            idx_q      <= '0;
                            par_err_q  <= 1'b0;
                            stop_err_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_hit_d) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= line_q;
                        if (idx_q == DATA_LAST) begin
                            idx_q   <= '0;
                            state_q <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_PARITY: begin
                    if (bit_hit_d) begin
                        cnt_q     <= '0;
                        par_err_q <= (^shift_q) ^ line_q ^ ODD_PARITY;
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (bit_hit_d) begin
                        cnt_q      <= '0;
                        stop_err_q <= stop_err_q | ~line_q;
                        if (idx_q == STOP_LAST) begin
                            idx_q  <= '0;
                            done_q <= 1'b1;
                            // A low final stop bit means the line may be in
                            // a break; wait for it to go high before looking
                            // for another start bit.
                            state_q <= line_q ? S_IDLE : S_WAIT_HIGH;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_WAIT_HIGH: begin
                    if (line_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready       = ready_q;
    assign data_out    = data_q;
    assign parity_ok_n = parity_q;
    assign frame_err   = frame_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_serial_rx_param.sv
// tb_serial_rx_param
//   Four receivers with different configurations, each on its own line:
//     dut0: 7 data bits, even parity, 1 stop, 16 clocks per bit
//     dut1: 7 data bits, odd parity,  1 stop, 16 clocks per bit
//     dut2: 7 data bits, no parity,   1 stop, 16 clocks per bit
//     dut3: 9 data bits, even parity, 2 stop,  4 clocks per bit
//   Expected words come from a frame-level model: data bits, parity by
//   counting ones, framing from the stop levels, and ready timing from the
//   bit-period arithmetic of the frame.
`timescale 1ns/1ps
module tb_serial_rx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ser = 4'hF;
    logic [3:0] ack = 4'h0;
    logic [3:0] rdy;
    logic [3:0] pok;
    logic [3:0] ferr;
    logic [3:0] ovr;
    logic [6:0] dout0;
    logic [6:0] dout1;
    logic [6:0] dout2;
    logic [8:0] dout3;
    logic [8:0] dout [4];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int cfg_n  [4] = '{16, 16, 16, 4};
    int cfg_db [4] = '{7, 7, 7, 9};
    int cfg_pm [4] = '{1, 2, 0, 1};
    int cfg_sb [4] = '{1, 1, 1, 2};

    int         rise_cnt [4] = '{0, 0, 0, 0};
    int         rise_cyc [4] = '{0, 0, 0, 0};
    logic [3:0] rdy_prev = 4'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_rx_param #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(16)) u_dut0 (
        .clk(clk), .rst(rst), .serial_in(ser[0]), .data_ack(ack[0]), .ready(rdy[0]),
        .data_out(dout0), .parity_ok_n(pok[0]), .frame_err(ferr[0]), .overrun(ovr[0]));
    serial_rx_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .CLKS_PER_BIT(16)) u_dut1 (
        .clk(clk), .rst(rst), .serial_in(ser[1]), .data_ack(ack[1]), .ready(rdy[1]),
        .data_out(dout1), .parity_ok_n(pok[1]), .frame_err(ferr[1]), .overrun(ovr[1]));
    serial_rx_param #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(16)) u_dut2 (
        .clk(clk), .rst(rst), .serial_in(ser[2]), .data_ack(ack[2]), .ready(rdy[2]),
        .data_out(dout2), .parity_ok_n(pok[2]), .frame_err(ferr[2]), .overrun(ovr[2]));
    serial_rx_param #(.DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(2), .CLKS_PER_BIT(4)) u_dut3 (
        .clk(clk), .rst(rst), .serial_in(ser[3]), .data_ack(ack[3]), .ready(rdy[3]),
        .data_out(dout3), .parity_ok_n(pok[3]), .frame_err(ferr[3]), .overrun(ovr[3]));

    assign dout[0] = {2'b00, dout0};
    assign dout[1] = {2'b00, dout1};
    assign dout[2] = {2'b00, dout2};
    assign dout[3] = dout3;

    // Record every rising edge of ready and the clock edge it happened on.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rdy[i] === 1'b1 && rdy_prev[i] !== 1'b1) begin
                rise_cnt[i] = rise_cnt[i] + 1;
                rise_cyc[i] = cyc;
            end
        end
        rdy_prev = rdy;
    end

    // ---------------- frame-level reference model ----------------
    function automatic int frame_len(input int id);
        return 1 + cfg_db[id] + ((cfg_pm[id] != 0) ? 1 : 0) + cfg_sb[id];
    endfunction

    // Clock edges from the cycle the start bit is driven to the edge where
    // ready rises: 2 synchroniser stages plus 1 to be seen in idle, then
    // half a bit, (F-1) further bits to the last stop sample, plus 1.
    function automatic int rise_delay(input int id);
        return 3 + cfg_n[id] / 2 + (frame_len(id) - 1) * cfg_n[id] + 1;
    endfunction

    function automatic logic [8:0] exp_data(input int id, input int data);
        return 9'(data & ((1 << cfg_db[id]) - 1));
    endfunction

    function automatic logic exp_par_n(input int id, input int data, input logic p);
        int ones;
        ones = $countones(data & ((1 << cfg_db[id]) - 1)) + (p ? 1 : 0);
        if (cfg_pm[id] == 0) return 1'b0;
        if (cfg_pm[id] == 1) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    function automatic logic exp_ferr(input int id, input logic [1:0] stops);
        for (int s = 0; s < cfg_sb[id]; s++) begin
            if (stops[s] == 1'b0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drives one whole frame; must be called just after a falling clock edge.
    task automatic send_frame(input int id, input int data, input logic p, input logic [1:0] stops);
        logic bits [$];
        bits.push_back(1'b0);
        for (int k = 0; k < cfg_db[id]; k++) bits.push_back(data[k]);
        if (cfg_pm[id] != 0) bits.push_back(p);
        for (int s = 0; s < cfg_sb[id]; s++) bits.push_back(stops[s]);
        foreach (bits[j]) begin
            ser[id] = bits[j];
            repeat (cfg_n[id]) @(negedge clk);
        end
        ser[id] = 1'b1;
    endtask

    task automatic ack_word(input int id);
        ack[id] = 1'b1;
        @(negedge clk);
        ack[id] = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rdy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b want 0", i, rdy[i]); end
            n_checks++; if (dout[i] !== 9'h0) begin n_fail++; $display("FAIL reset_data dut%0d: got %h want 0", i, dout[i]); end
            n_checks++; if (pok[i] !== 1'b0) begin n_fail++; $display("FAIL reset_parity dut%0d: got %b want 0", i, pok[i]); end
            n_checks++; if (ferr[i] !== 1'b0) begin n_fail++; $display("FAIL reset_frame dut%0d: got %b want 0", i, ferr[i]); end
            n_checks++; if (ovr[i] !== 1'b0) begin n_fail++; $display("FAIL reset_overrun dut%0d: got %b want 0", i, ovr[i]); end
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (rdy !== 4'h0) begin n_fail++; $display("FAIL idle_after_reset: ready %b want 0000", rdy); end
        $display("test_reset done");
    endtask

    task automatic test_parity_modes();
        int   ids   [6] = '{0, 0, 1, 1, 2, 2};
        int   datas [6] = '{'h55, 'h55, 'h55, 'h55, 'h55, 'h2B};
        logic ps    [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int id, r0, c0;
        for (int k = 0; k < 6; k++) begin
            id = ids[k];
            r0 = rise_cnt[id];
            c0 = cyc;
            send_frame(id, datas[k], ps[k], 2'b11);
            repeat (8) @(negedge clk);
            n_checks++; if (rise_cnt[id] - r0 !== 1) begin n_fail++; $display("FAIL parity_rise dut%0d: %0d rises want 1", id, rise_cnt[id] - r0); end
            n_checks++; if (rise_cyc[id] - c0 !== rise_delay(id)) begin n_fail++; $display("FAIL parity_timing dut%0d: %0d want %0d", id, rise_cyc[id] - c0, rise_delay(id)); end
            n_checks++; if (dout[id] !== exp_data(id, datas[k])) begin n_fail++; $display("FAIL parity_data dut%0d: got %h want %h", id, dout[id], exp_data(id, datas[k])); end
            n_checks++; if (pok[id] !== exp_par_n(id, datas[k], ps[k])) begin n_fail++; $display("FAIL parity_flag dut%0d: got %b want %b", id, pok[id], exp_par_n(id, datas[k], ps[k])); end
            n_checks++; if (ferr[id] !== 1'b0) begin n_fail++; $display("FAIL parity_frame dut%0d: got %b want 0", id, ferr[id]); end
            if (k == 0) begin
                // t0 is three edges after the start bit is driven.
                n_checks++; if (rise_cyc[id] - (c0 + 3) !== 153) begin n_fail++; $display("FAIL latency_t0: %0d want 153", rise_cyc[id] - (c0 + 3)); end
                repeat (30) @(negedge clk);
                n_checks++; if (rdy[id] !== 1'b1) begin n_fail++; $display("FAIL ready_hold: got %b want 1", rdy[id]); end
            end
            ack_word(id);
            n_checks++; if (rdy[id] !== 1'b0) begin n_fail++; $display("FAIL parity_ack dut%0d: ready %b want 0", id, rdy[id]); end
            $display("parity dut%0d data %h p %0d -> data_out %h parity_ok_n %b", id, datas[k], ps[k], dout[id], pok[id]);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_random_frames();
        int id, data, r0, c0;
        logic p;
        logic [1:0] stops;
        for (int k = 0; k < 12; k++) begin
            id    = int'($urandom_range(0, 3));
            data  = int'($urandom_range(0, 511));
            p     = 1'($urandom_range(0, 1));
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            r0 = rise_cnt[id];
            c0 = cyc;
            send_frame(id, data, p, stops);
            repeat (8) @(negedge clk);
            n_checks++; if (rise_cnt[id] - r0 !== 1) begin n_fail++; $display("FAIL rand_rise dut%0d: %0d rises want 1", id, rise_cnt[id] - r0); end
            n_checks++; if (rise_cyc[id] - c0 !== rise_delay(id)) begin n_fail++; $display("FAIL rand_timing dut%0d: %0d want %0d", id, rise_cyc[id] - c0, rise_delay(id)); end
            n_checks++; if (dout[id] !== exp_data(id, data)) begin n_fail++; $display("FAIL rand_data dut%0d: got %h want %h", id, dout[id], exp_data(id, data)); end
            n_checks++; if (pok[id] !== exp_par_n(id, data, p)) begin n_fail++; $display("FAIL rand_parity dut%0d: got %b want %b", id, pok[id], exp_par_n(id, data, p)); end
            n_checks++; if (ferr[id] !== exp_ferr(id, stops)) begin n_fail++; $display("FAIL rand_frame dut%0d: got %b want %b", id, ferr[id], exp_ferr(id, stops)); end
            ack_word(id);
            n_checks++; if (rdy[id] !== 1'b0) begin n_fail++; $display("FAIL rand_ack dut%0d: ready %b want 0", id, rdy[id]); end
            $display("random dut%0d data %h p %0d stops %b -> data_out %h pok %b ferr %b", id, data, p, stops, dout[id], pok[id], ferr[id]);
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic test_false_start();
        int r0, c0;
        r0 = rise_cnt[0];
        ser[0] = 1'b0;
        repeat (5) @(negedge clk);
        ser[0] = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++; if (rise_cnt[0] - r0 !== 0) begin n_fail++; $display("FAIL glitch_rejected: %0d rises want 0", rise_cnt[0] - r0); end
        c0 = cyc;
        send_frame(0, 'h2A, 1'b1, 2'b11);
        repeat (8) @(negedge clk);
        n_checks++; if (rise_cnt[0] - r0 !== 1) begin n_fail++; $display("FAIL after_glitch_rise: %0d rises want 1", rise_cnt[0] - r0); end
        n_checks++; if (rise_cyc[0] - c0 !== rise_delay(0)) begin n_fail++; $display("FAIL after_glitch_timing: %0d want %0d", rise_cyc[0] - c0, rise_delay(0)); end
        n_checks++; if (dout[0] !== 9'h02A) begin n_fail++; $display("FAIL after_glitch_data: got %h want 02a", dout[0]); end
        n_checks++; if (pok[0] !== 1'b0) begin n_fail++; $display("FAIL after_glitch_parity: got %b want 0", pok[0]); end
        $display("false start then 2a -> data_out %h", dout[0]);
        ack_word(0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_break();
        int r0, c0;
        r0 = rise_cnt[0];
        c0 = cyc;
        ser[0] = 1'b0;
        repeat (3 * frame_len(0) * cfg_n[0]) @(negedge clk);
        n_checks++; if (rise_cnt[0] - r0 !== 1) begin n_fail++; $display("FAIL break_words: %0d want 1", rise_cnt[0] - r0); end
        n_checks++; if (rise_cyc[0] - c0 !== rise_delay(0)) begin n_fail++; $display("FAIL break_timing: %0d want %0d", rise_cyc[0] - c0, rise_delay(0)); end
        n_checks++; if (dout[0] !== 9'h000) begin n_fail++; $display("FAIL break_data: got %h want 000", dout[0]); end
        n_checks++; if (ferr[0] !== 1'b1) begin n_fail++; $display("FAIL break_frame: got %b want 1", ferr[0]); end
        n_checks++; if (pok[0] !== exp_par_n(0, 0, 1'b0)) begin n_fail++; $display("FAIL break_parity: got %b want %b", pok[0], exp_par_n(0, 0, 1'b0)); end
        ack_word(0);
        repeat (100) @(negedge clk);
        n_checks++; if (rise_cnt[0] - r0 !== 1 || rdy[0] !== 1'b0) begin n_fail++; $display("FAIL break_quiet: rises %0d ready %b want 1 and 0", rise_cnt[0] - r0, rdy[0]); end
        ser[0] = 1'b1;
        repeat (10) @(negedge clk);
        c0 = cyc;
        send_frame(0, 'h3C, 1'b0, 2'b11);
        repeat (8) @(negedge clk);
        n_checks++; if (rise_cnt[0] - r0 !== 2) begin n_fail++; $display("FAIL break_recover_rise: %0d want 2", rise_cnt[0] - r0); end
        n_checks++; if (dout[0] !== 9'h03C || ferr[0] !== 1'b0) begin n_fail++; $display("FAIL break_recover_word: data %h ferr %b want 03c 0", dout[0], ferr[0]); end
        $display("break -> one word, recovered data_out %h", dout[0]);
        ack_word(0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int c0b;
        send_frame(0, 'h11, 1'b0, 2'b11);
        send_frame(0, 'h22, 1'b0, 2'b11);
        repeat (8) @(negedge clk);
        n_checks++; if (dout[0] !== 9'h022) begin n_fail++; $display("FAIL b2b_data: got %h want 022", dout[0]); end
        n_checks++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", rdy[0]); end
        n_checks++; if (ovr[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", ovr[0]); end
        ack_word(0);
        n_checks++; if (rdy[0] !== 1'b0 || ovr[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_ack: ready %b overrun %b want 0 0", rdy[0], ovr[0]); end
        $display("back to back 11,22 -> data_out %h, cleared by ack", dout[0]);
        repeat (4) @(negedge clk);

        send_frame(0, 'h33, 1'b0, 2'b11);
        c0b = cyc;
        fork
            send_frame(0, 'h44, 1'b1, 2'b11);
            begin
                while (cyc < c0b + rise_delay(0) - 1) @(negedge clk);
                ack[0] = 1'b1;
                @(negedge clk);
                ack[0] = 1'b0;
            end
        join
        repeat (8) @(negedge clk);
        n_checks++; if (dout[0] !== 9'h044) begin n_fail++; $display("FAIL ackcomp_data: got %h want 044", dout[0]); end
        n_checks++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL ackcomp_ready: got %b want 1", rdy[0]); end
        n_checks++; if (ovr[0] !== 1'b0) begin n_fail++; $display("FAIL ackcomp_overrun: got %b want 0", ovr[0]); end
        $display("ack on completion 33,44 -> data_out %h overrun %b", dout[0], ovr[0]);
        ack_word(0);
        n_checks++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL ackcomp_final: ready %b want 0", rdy[0]); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wide_frame();
        int r0, c0;
        r0 = rise_cnt[3];
        c0 = cyc;
        send_frame(3, 'h1A5, 1'b1, 2'b01);
        repeat (8) @(negedge clk);
        n_checks++; if (rise_cnt[3] - r0 !== 1) begin n_fail++; $display("FAIL wide_rise: %0d want 1", rise_cnt[3] - r0); end
        n_checks++; if (rise_cyc[3] - c0 !== 54) begin n_fail++; $display("FAIL wide_timing: %0d want 54", rise_cyc[3] - c0); end
        n_checks++; if (dout[3] !== 9'h1A5) begin n_fail++; $display("FAIL wide_data: got %h want 1a5", dout[3]); end
        n_checks++; if (ferr[3] !== 1'b1) begin n_fail++; $display("FAIL wide_frame: got %b want 1", ferr[3]); end
        n_checks++; if (pok[3] !== 1'b0) begin n_fail++; $display("FAIL wide_parity: got %b want 0", pok[3]); end
        $display("wide 1a5 second stop low -> data_out %h frame_err %b", dout[3], ferr[3]);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int r0, c0, data;
        // dut3 still holds the previous word; start a frame and cut it off.
        ser[3] = 1'b0; repeat (6) @(negedge clk);
        ser[3] = 1'b1; repeat (4) @(negedge clk);
        ser[3] = 1'b0; repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdy[i] !== 1'b0 || dout[i] !== 9'h0 || pok[i] !== 1'b0 || ferr[i] !== 1'b0 || ovr[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_outputs dut%0d: ready %b data %h pok %b ferr %b ovr %b want all 0", i, rdy[i], dout[i], pok[i], ferr[i], ovr[i]);
            end
        end
        @(negedge clk);
        ser[3] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r0 = rise_cnt[3];
        repeat (100) @(negedge clk);
        n_checks++; if (rise_cnt[3] - r0 !== 0 || rdy[3] !== 1'b0) begin n_fail++; $display("FAIL midreset_discard: rises %0d ready %b want 0 0", rise_cnt[3] - r0, rdy[3]); end
        data = int'($urandom_range(0, 511));
        c0 = cyc;
        send_frame(3, data, 1'b0, 2'b11);
        repeat (8) @(negedge clk);
        n_checks++; if (rise_cyc[3] - c0 !== rise_delay(3)) begin n_fail++; $display("FAIL midreset_new_timing: %0d want %0d", rise_cyc[3] - c0, rise_delay(3)); end
        n_checks++; if (dout[3] !== exp_data(3, data) || pok[3] !== exp_par_n(3, data, 1'b0)) begin n_fail++; $display("FAIL midreset_new_word: data %h pok %b want %h %b", dout[3], pok[3], exp_data(3, data), exp_par_n(3, data, 1'b0)); end
        $display("reset mid-frame, then data %h -> data_out %h", data, dout[3]);
        ack_word(3);
    endtask

    initial begin
        test_reset();
        test_parity_modes();
        test_random_frames();
        test_false_start();
        test_break();
        test_back_to_back();
        test_wide_frame();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_rx_param.md
# serial_rx_param

Parametrised asynchronous serial receiver that succeeds the fixed 7-data-bit, one-bit-per-clock receiver. It adds a configurable data width, parity mode, stop-bit count and oversampled bit period with mid-bit sampling. It also adds an input synchroniser, false-start rejection, framing-error detection, and a held-output handshake with overrun flag. It sits between the serial line pin and the byte-consuming logic.

## Interface
- DATA_BITS, 7: data bits per frame; legal range 5..9, sent LSB first.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- CLKS_PER_BIT, 16: clk cycles per bit, N; legal range 4..65535. Define H = N/2 (integer division).
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  line, idle high; asynchronous to clk.
- data_ack  input  1  consumer accepts the held word; ignored while ready=0.
- ready  output  1  held word valid; stays high until acknowledged.
- data_out  output  DATA_BITS  received data, bit 0 = first data bit received.
- parity_ok_n  output  1  0 = parity correct or PARITY_MODE=0; 1 = parity error.
- frame_err  output  1  1 = a stop bit was sampled low in the held word.
- overrun  output  1  sticky; a held word was overwritten before being acknowledged.

## Operation
- Synchroniser: 2 flops on serial_in, both reset to 1. "line" below means the synchroniser output.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. A single bit-period counter (clog2(N) bits) and a bit index counter (clog2(DATA_BITS) bits).
- IDLE: when line=0, go to START and clear the counter.
- START: at count H, sample line.
  - If line=1, treat as a false start and return to IDLE; no outputs change.
  - Otherwise go to DATA.
- DATA: every N cycles, sample one bit into shift-register position bit_idx, LSB first. After DATA_BITS samples, go to PARITY (if PARITY_MODE≠0) or STOP.
- PARITY: sample one bit after N cycles.
  - Even mode: parity_ok_n = XOR(data, p).
  - Odd mode: parity_ok_n = ~XOR(data, p).
  - Mode 0: parity_ok_n = 0.
- STOP: sample STOP_BITS bits, each N cycles apart. frame_err = 1 if any stop sample is 0.
- Completion, on the edge after the last stop sample:
  - Load data_out, parity_ok_n and frame_err; set ready=1.
  - Then go to IDLE if that stop sample was 1, else go to WAIT_HIGH.
- WAIT_HIGH: stay until line=1, then go to IDLE. A stuck-low line or break therefore yields exactly one frame_err word.
- Handshake rules:
  - data_ack while ready=1 clears ready on the next edge.
  - Completion while ready=1 and data_ack=0: overwrite data_out, parity_ok_n and frame_err; set overrun=1.
  - Completion and data_ack in the same cycle: load the new word, ready stays 1, overrun is not set.
  - data_ack clears overrun, unless the same cycle also sets it through a new overrun.
- Reset (asynchronous, any time including mid-frame):
  - State IDLE; counters 0; synchroniser 1,1.
  - ready=0, data_out=0, parity_ok_n=0, frame_err=0, overrun=0.
  - The partial frame is discarded. After release, no frame is reported until a new start edge.

## Timing
- Latency from serial_in to line: 2 cycles.
- Let t0 be the edge at which IDLE first sees line=0. Sample edges are:
  - start bit at t0+H;
  - data bit k at t0+H+(k+1)·N;
  - parity bit at t0+H+(DATA_BITS+1)·N;
  - stop bits at the following multiples of N.
- Let F = 1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS. The last sample is at t0+H+(F−1)·N; ready rises at t0+H+(F−1)·N+1.
- Back-to-back frames: the next start edge may arrive immediately after the stop bit(s) with no extra idle time. IDLE is re-entered within H+1 cycles of the stop-bit midpoint.
- Outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Defaults (N=16, 7 data bits, even parity, 1 stop): send 0x55 with p=0 → data_out=0x55, parity_ok_n=0, frame_err=0. ready rises 153 cycles after t0 and holds until data_ack; ready is low one cycle after data_ack.
- Defaults: send 0x55 with p=1 → parity_ok_n=1. PARITY_MODE=2 with 0x55, p=1 → parity_ok_n=0. PARITY_MODE=0 → parity_ok_n=0 always.
- Drive a 5-cycle low glitch, then high → START rejects it: no ready, state back in IDLE. Then a valid 0x2A frame is received correctly.
- Hold the line low for 3 frame times → exactly one word with data_out=0x00 and frame_err=1. No further ready until the line returns high, after which a new frame is received.
- Two frames 0x11 and 0x22 with no data_ack → data_out=0x22, overrun=1. data_ack → ready=0, overrun=0. Repeat with data_ack on the completion cycle → ready stays 1, overrun stays 0.
- DATA_BITS=9, STOP_BITS=2, N=4: send 0x1A5, second stop bit low → data_out=0x1A5, frame_err=1. Assert rst mid-frame → all outputs 0 and the partial frame is discarded.
